dma_copy: RTL and testbench

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_copy.sv | 155 +++++++++++++++
 tb/tb_dma_copy.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy word-copy engine: FSM state encoding
// and the default per-word address increment.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_STEP = 4;

endpackage

// File: rtl/dma_copy.sv
// Single-channel memory-to-memory copy engine: alternating READ/WRITE bus cycles,
// two cycles per word. Define DMA_COPY_IRQ_EN to add a sticky completion interrupt.
module dma_copy
  import dma_pkg::*;
#(
  parameter int          LEN_W = 16,
  parameter int unsigned STEP  = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata
`ifdef DMA_COPY_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_rd;
  logic             r_wr;
  logic [31:0]      r_addr;

  logic [31:0]      w_src_next;
  logic [31:0]      w_dst_next;
  logic [LEN_W-1:0] w_cnt_dec;

  // 32-bit adders wrap naturally, which is the intended address behaviour.
  assign w_src_next = r_src + 32'(STEP);
  assign w_dst_next = r_dst + 32'(STEP);
  assign w_cnt_dec  = r_cnt - LEN_W'(1);

  // NOTE: every state and bus output is a register with async reset, so a reset
  // drops the strobes immediately; outputs are computed from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
    end else begin
      // NOTE: non-blocking assignments only; the default below is overridden later in the block.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_cnt   <= len;
              r_state <= READ;
              r_rd    <= 1'b1;
              r_addr  <= src_addr;
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          r_data <= rdata;
          r_rd   <= 1'b0;
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_state <= WRITE;
            r_wr    <= 1'b1;
            r_addr  <= r_dst;
          end
        end
        WRITE: begin
          r_src <= w_src_next;
          r_dst <= w_dst_next;
          r_cnt <= w_cnt_dec;
          r_wr  <= 1'b0;
          if (abort) begin
            // Abort wins over completion: no done pulse even on the last word.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_addr  <= '0;
          end else if (w_cnt_dec == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_addr  <= '0;
          end else begin
            r_state <= READ;
            r_rd    <= 1'b1;
            r_addr  <= w_src_next;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_addr  <= '0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rd    = r_rd;
  assign wr    = r_wr;
  assign addr  = r_addr;
  assign wdata = r_wr ? r_data : '0;

`ifdef DMA_COPY_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else if (r_done) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: stimulus queues expected bus events, a negedge
// monitor pops and compares them; optional irq checks under DMA_COPY_IRQ_EN.
module tb_dma_copy;

  typedef enum logic [1:0] {EV_RD = 2'd0, EV_WR = 2'd1, EV_DONE = 2'd2} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
`ifdef DMA_COPY_IRQ_EN
  logic        irq_clr;
  logic        irq;
`endif

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  busy_cycles = 0;
  int  done_cycle = 0;
  logic prev_busy = 1'b0;

  dma_copy #(.LEN_W(16), .STEP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata)
`ifdef DMA_COPY_IRQ_EN
    ,
    .irq_clr  (irq_clr),
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  // Bus memory model: three fixed words at 0x100, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_000A;
      32'h0000_0104: return 32'h0000_000B;
      32'h0000_0108: return 32'h0000_000C;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign rdata = rd ? mem_word(addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      if (k != EV_DONE) check("ev_addr", a, e.a);
      if (k == EV_WR) check("ev_wdata", d, e.d);
    end
  endtask

  // Monitor: observe the bus away from the active edge.
  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) begin
        busy_cycles = 1;
        done_cycle  = 0;
      end else begin
        busy_cycles++;
      end
      if (done) done_cycle = busy_cycles;
    end
    prev_busy = busy;

    if (rd || wr) check("rd_wr_excl", {31'b0, rd & wr}, 32'd0);
    if (!busy) begin
      check("idle_strobes", {29'b0, rd, wr, done}, 32'd0);
      check("idle_bus", addr | wdata, 32'd0);
    end
    if (done) check("fin_bus", addr | wdata | {30'b0, rd, wr}, 32'd0);

    if (rd) expect_ev(EV_RD, addr, 32'h0);
    else if (wr) expect_ev(EV_WR, addr, wdata);
    if (done) expect_ev(EV_DONE, 32'h0, 32'h0);
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk); #1;
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_strobe(input bit want_wr, input int nth);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (want_wr ? wr : rd) seen++;
      if (seen == nth) break;
    end
    check("strobe_seen", 32'(seen), 32'(nth));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
`ifdef DMA_COPY_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rdwr", {30'b0, rd, wr}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
`ifdef DMA_COPY_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'd0);
`endif
    @(negedge clk); reset = 1'b1;

    // Basic three-word copy
    push(EV_RD, 32'h100, 0); push(EV_WR, 32'h200, 32'hA);
    push(EV_RD, 32'h104, 0); push(EV_WR, 32'h204, 32'hB);
    push(EV_RD, 32'h108, 0); push(EV_WR, 32'h208, 32'hC);
    push(EV_DONE, 0, 0);
    kick(32'h100, 32'h200, 16'd3);
    wait_idle(40);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd7);
    check("t1_done_cycle", 32'(done_cycle), 32'd7);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length copy
    push(EV_DONE, 0, 0);
    kick(32'h1000, 32'h2000, 16'd0);
    wait_idle(10);
    check("t2_busy_cycles", 32'(busy_cycles), 32'd1);
    check("t2_done_cycle", 32'(done_cycle), 32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef DMA_COPY_IRQ_EN
    check("irq_set", {31'b0, irq}, 32'd1);
    repeat (2) @(negedge clk);
    check("irq_hold", {31'b0, irq}, 32'd1);
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check("irq_clr", {31'b0, irq}, 32'd0);
`endif

    // Source address wraps past 2^32
    push(EV_RD, 32'hFFFF_FFFC, 0); push(EV_WR, 32'h300, 32'hA5A5_FFFC);
    push(EV_RD, 32'h0000_0000, 0); push(EV_WR, 32'h304, 32'h5A5A_0000);
    push(EV_DONE, 0, 0);
    kick(32'hFFFF_FFFC, 32'h300, 16'd2);
    wait_idle(20);
    check("t3_busy_cycles", 32'(busy_cycles), 32'd5);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort during second READ of a 4-word copy
    push(EV_RD, 32'h400, 0); push(EV_WR, 32'h500, 32'h5A5A_0400);
    push(EV_RD, 32'h404, 0);
    kick(32'h400, 32'h500, 16'd4);
    wait_strobe(1'b0, 1);
    wait_strobe(1'b0, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    check("t4_idle_after_abort", {31'b0, busy}, 32'd0);
    check("t4_busy_cycles", 32'(busy_cycles), 32'd3);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // start while busy must not re-latch
    push(EV_RD, 32'h600, 0); push(EV_WR, 32'h700, 32'h5A5A_0600);
    push(EV_RD, 32'h604, 0); push(EV_WR, 32'h704, 32'h5A5A_0604);
    push(EV_DONE, 0, 0);
    kick(32'h600, 32'h700, 16'd2);
    src_addr = 32'h900; dst_addr = 32'h980; len = 16'd5; start = 1'b1;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    wait_idle(30);
    check("t5_busy_cycles", 32'(busy_cycles), 32'd5);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort coinciding with the last WRITE suppresses done
    push(EV_RD, 32'hA00, 0); push(EV_WR, 32'hB00, 32'h5A5A_0A00);
    kick(32'hA00, 32'hB00, 16'd1);
    wait_strobe(1'b1, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    check("t6_idle_after_abort", {31'b0, busy}, 32'd0);
    check("t6_busy_cycles", 32'(busy_cycles), 32'd2);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort in IDLE and in FIN has no effect
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1; abort = 1'b0;
    check("t7_idle_abort", {31'b0, busy}, 32'd0);
    push(EV_RD, 32'hC00, 0); push(EV_WR, 32'hD00, 32'h5A5A_0C00);
    push(EV_DONE, 0, 0);
    kick(32'hC00, 32'hD00, 16'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(5);
    check("t7_done_cycle", 32'(done_cycle), 32'd3);
    check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during WRITE drops strobes before the next edge
    push(EV_RD, 32'hE00, 0); push(EV_WR, 32'hF00, 32'h5A5A_0E00);
    kick(32'hE00, 32'hF00, 16'd2);
    wait_strobe(1'b1, 1);
    #1 reset = 1'b0;
    #1;
    check("t8_rst_rdwr", {30'b0, rd, wr}, 32'd0);
    check("t8_rst_busy", {31'b0, busy}, 32'd0);
    check("t8_rst_addr", addr, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t8_stays_idle", {31'b0, busy}, 32'd0);
    check("t8_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
